// File: rtl/branch_redirect_ctrl.sv
// Control-flow redirect sequencer: captures a resolved branch/jump in EX, holds the
// target until fetch accepts it, then flushes IF/ID. Optional macro: BRANCH_PREDICT_EN.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_is_branch,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic            i_taken,
`ifdef BRANCH_PREDICT_EN
    input  logic            i_pred_taken,
`endif
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic            i_stall,
    input  logic            i_fetch_ready,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic            o_busy,
    output logic            o_misalign
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    logic [1:0]      state_q;
    logic [3:0]      cnt_q;
    logic [XLEN-1:0] target_q;
    logic            misalign_q;

    logic            need;
    logic [XLEN-1:0] target;
    logic            capture;

    // Flag priority jalr > jal > branch resolves illegal multi-flag encodings.
    always_comb begin
        need   = 1'b0;
        target = i_pc + i_imm;
        if (i_is_jalr) begin
            need   = 1'b1;
            target = (i_rs1 + i_imm) & {{(XLEN-1){1'b1}}, 1'b0};
        end else if (i_is_jal) begin
            need = 1'b1;
        end else if (i_is_branch) begin
`ifdef BRANCH_PREDICT_EN
            need = i_taken ^ i_pred_taken;
            if (!i_taken) begin
                target = i_pc + XLEN'(4);
            end
`else
            need = i_taken;
`endif
        end
    end

    assign capture = (state_q == IDLE) && i_valid && !i_stall && need;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        if (target[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end else begin
                            target_q <= target;
                            state_q  <= REDIRECT;
                        end
                    end
                end
                REDIRECT: begin
                    if (i_fetch_ready) begin
                        cnt_q   <= 4'(FLUSH_CYCLES);
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_redirect_valid = (state_q == REDIRECT);
    assign o_redirect_pc    = target_q;
    assign o_flush          = (state_q != IDLE);
    assign o_busy           = (state_q != IDLE);
    assign o_misalign       = misalign_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: driver pushes expected redirect/misalign
// events from a reference model; a negedge monitor pops and checks them.
module tb_branch_redirect_ctrl;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            i_is_branch = 1'b0;
    logic            i_is_jal = 1'b0;
    logic            i_is_jalr = 1'b0;
    logic            i_taken = 1'b0;
    logic            i_pred_taken = 1'b0;
    logic [XLEN-1:0] i_pc = '0;
    logic [XLEN-1:0] i_imm = '0;
    logic [XLEN-1:0] i_rs1 = '0;
    logic            i_stall = 1'b0;
    logic            i_fetch_ready = 1'b0;
    logic            o_redirect_valid;
    logic [XLEN-1:0] o_redirect_pc;
    logic            o_flush;
    logic            o_busy;
    logic            o_misalign;

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_is_branch(i_is_branch), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
        .i_taken(i_taken),
`ifdef BRANCH_PREDICT_EN
        .i_pred_taken(i_pred_taken),
`endif
        .i_pc(i_pc), .i_imm(i_imm), .i_rs1(i_rs1), .i_stall(i_stall),
        .i_fetch_ready(i_fetch_ready), .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc(o_redirect_pc), .o_flush(o_flush), .o_busy(o_busy),
        .o_misalign(o_misalign)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int              kind;   // 1 = redirect, 2 = misalign
        logic [XLEN-1:0] pc;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   rst_q = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always @(posedge i_clk) begin
        cyc   <= cyc + 1;
        rst_q <= i_rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a single EX instruction should produce when the controller is idle.
    function automatic int model(input bit v, input bit br, input bit jal, input bit jalr,
                                 input bit tk, input bit pt, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                                 input bit st, output logic [XLEN-1:0] t);
        t = '0;
        if (!v || st) return 0;
        if (jalr) begin
            t = rs1 + imm;
            t = t - (t % 2);
        end else if (jal) begin
            t = pc + imm;
        end else if (br) begin
`ifdef BRANCH_PREDICT_EN
            if (tk == pt) return 0;
            t = tk ? pc + imm : pc + 4;
`else
            if (!tk) return 0;
            t = pc + imm;
`endif
        end else begin
            return 0;
        end
        return (t % 4 == 0) ? 1 : 2;
    endfunction

    task automatic drive(input bit rst, input bit v, input bit br, input bit jal, input bit jalr,
                         input bit tk, input bit pt, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                         input bit st, input bit fr);
        logic [XLEN-1:0] t;
        int              act;
        exp_t            e;
        i_rst = rst; i_valid = v; i_is_branch = br; i_is_jal = jal; i_is_jalr = jalr;
        i_taken = tk; i_pred_taken = pt; i_pc = pc; i_imm = imm; i_rs1 = rs1;
        i_stall = st; i_fetch_ready = fr;
        if (!rst && o_busy === 1'b0) begin
            act = model(v, br, jal, jalr, tk, pt, pc, imm, rs1, st, t);
            if (act != 0) begin
                e.kind = act; e.pc = t; e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input bit fr, input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 0, fr);
    endtask

    task automatic pop_cmp(input int kind, input logic [XLEN-1:0] pc, input bit chk_pc);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output kind=%0d pc=%0h required=no output (cycle %0d)",
                     kind, pc, cyc);
            return;
        end
        e = q.pop_front();
        check("event_kind", 64'(kind), 64'(e.kind));
        check("event_latency", 64'(cyc), 64'(e.cyc));
        if (chk_pc) check("redirect_target", 64'(pc), 64'(e.pc));
    endtask

    bit              in_redir = 1'b0;
    bit              flushing = 1'b0;
    int              fcount = 0;
    logic [XLEN-1:0] hold_pc = '0;

    initial begin
        forever begin
            @(negedge i_clk);
            if (rst_q) begin
                check("rst_redirect_valid", 64'(o_redirect_valid), 64'd0);
                check("rst_redirect_pc", 64'(o_redirect_pc), 64'd0);
                check("rst_flush", 64'(o_flush), 64'd0);
                check("rst_busy", 64'(o_busy), 64'd0);
                check("rst_misalign", 64'(o_misalign), 64'd0);
                in_redir = 1'b0;
                flushing = 1'b0;
                continue;
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_output kind=%0d actual=none required_cycle=%0d", q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
            check("misalign_vs_redirect", 64'(o_misalign & o_redirect_valid), 64'd0);
            check("busy_matches_flush", 64'(o_busy), 64'(o_flush));
            if (o_misalign) begin
                check("misalign_busy", 64'(o_busy), 64'd0);
                pop_cmp(2, '0, 1'b0);
            end
            if (o_redirect_valid) begin
                if (!in_redir) begin
                    if (flushing) check("flush_len", 64'(fcount), 64'(FC));
                    flushing = 1'b0;
                    pop_cmp(1, o_redirect_pc, 1'b1);
                    hold_pc  = o_redirect_pc;
                    in_redir = 1'b1;
                end else begin
                    check("redirect_pc_stable", 64'(o_redirect_pc), 64'(hold_pc));
                end
                check("redirect_flush", 64'(o_flush), 64'd1);
                if (i_fetch_ready) begin
                    in_redir = 1'b0;
                    flushing = 1'b1;
                    fcount   = 0;
                end
            end else begin
                if (in_redir) begin
                    checks++;
                    failures++;
                    $display("FAIL redirect_dropped actual=valid low required=valid held (cycle %0d)", cyc);
                    in_redir = 1'b0;
                end
                if (flushing) begin
                    if (o_flush) begin
                        fcount++;
                    end else begin
                        check("flush_len", 64'(fcount), 64'(FC));
                        flushing = 1'b0;
                    end
                end else begin
                    check("idle_flush", 64'(o_flush), 64'd0);
                end
            end
        end
    end

    initial begin
        int r;
        logic [XLEN-1:0] pc, imm, rs1;
        repeat (3) @(posedge i_clk);
        #1;
        // Taken branch with immediate acceptance.
        drive(0, 1, 1, 0, 0, 1, 0, 32'h100, 32'h20, '0, 0, 1);
        idle(1, 5);
        // JALR held three cycles before fetch accepts.
        drive(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h1, 32'h2003, 0, 0);
        idle(0, 3);
        idle(1, 5);
        // Misaligned JAL.
        drive(0, 1, 0, 1, 0, 0, 0, 32'h100, 32'h6, '0, 0, 1);
        idle(1, 3);
        // Not-taken branch, then stalled taken branch.
        drive(0, 1, 1, 0, 0, 0, 0, 32'h100, 32'h20, '0, 0, 1);
        drive(0, 1, 1, 0, 0, 1, 0, 32'h100, 32'h20, '0, 1, 1);
        idle(1, 3);
        // Reset during the last flush cycle, then an immediate new branch.
        drive(0, 1, 1, 0, 0, 1, 0, 32'h100, 32'h20, '0, 0, 1);
        idle(1, 2);
        drive(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, 0, 1);
        drive(0, 1, 1, 0, 0, 1, 0, 32'h300, 32'h40, '0, 0, 1);
        idle(1, 5);
        // Reset while the redirect is still waiting.
        drive(0, 1, 0, 1, 0, 0, 0, 32'h400, 32'h80, '0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, 0, 0);
        idle(1, 3);
`ifdef BRANCH_PREDICT_EN
        drive(0, 1, 1, 0, 0, 0, 1, 32'h200, 32'h40, '0, 0, 1);
        idle(1, 5);
        drive(0, 1, 1, 0, 0, 1, 1, 32'h200, 32'h40, '0, 0, 1);
        idle(1, 3);
`endif
        for (int n = 0; n < 3000; n++) begin
            r   = int'($urandom_range(0, 8));
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rs1 = $urandom;
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                  (r <= 3), (r == 4 || r == 5), (r == 6 || r == 7),
                  1'($urandom), 1'($urandom), pc, imm, rs1,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
        end
        idle(1, 20);
        check("scoreboard_drained", 64'(q.size()), 64'd0);
        check("final_busy", 64'(o_busy), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
